// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator
//   Accumulates a programmable-length run of unsigned products coming from a
//   non-stallable multiplier and queues each finished dot product in a
//   2-entry FIFO toward the next stage.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, vec_len      begin a vector of vec_len products (ignored if 0 or busy)
//   flush               abort the vector in progress, nothing is queued
//   prod_valid/data     one unsigned product per pulse
//   res_valid/ready     FIFO head handshake; res_data/res_ovf show the head
//   busy                high while a vector is being accumulated
//   err_clr             clears both sticky error flags
//   err_overrun         sticky: finished result dropped because FIFO was full
//   err_stray           sticky: product arrived while idle
module dot_product_accumulator #(
  parameter int PROD_WIDTH = 17,
  parameter int ACC_WIDTH  = 24,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  vec_len,
  input  logic                  flush,
  input  logic                  prod_valid,
  input  logic [PROD_WIDTH-1:0] prod_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_WIDTH-1:0]  res_data,
  output logic                  res_ovf,
  output logic                  busy,
  input  logic                  err_clr,
  output logic                  err_overrun,
  output logic                  err_stray
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                 state_reg;
  logic [LEN_WIDTH-1:0]   len_reg;
  logic [LEN_WIDTH-1:0]   count_reg;
  logic [ACC_WIDTH-1:0]   acc_reg;
  logic                   ovf_reg;

  // One extra bit on the sum captures the carry out of the accumulator.
  logic [ACC_WIDTH:0]     sum_next;
  logic                   ovf_next;
  logic [LEN_WIDTH:0]     count_inc;
  logic                   accept_prod;
  logic                   last_prod;

  assign sum_next    = {1'b0, acc_reg} + {{(ACC_WIDTH + 1 - PROD_WIDTH){1'b0}}, prod_data};
  assign ovf_next    = ovf_reg | sum_next[ACC_WIDTH];
  assign count_inc   = {1'b0, count_reg} + {{LEN_WIDTH{1'b0}}, 1'b1};
  // flush wins over a product arriving in the same cycle
  assign accept_prod = (state_reg == ACCUM) && prod_valid && !flush;
  assign last_prod   = accept_prod && (count_inc == {1'b0, len_reg});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      count_reg <= '0;
      acc_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && (vec_len != '0)) begin
            len_reg   <= vec_len;
            count_reg <= '0;
            acc_reg   <= '0;
            ovf_reg   <= 1'b0;
            state_reg <= ACCUM;
          end
        end
        ACCUM: begin
          if (flush) begin
            state_reg <= IDLE;
          end else if (prod_valid) begin
            if (last_prod) begin
              // final sum goes straight into the FIFO this cycle
              state_reg <= IDLE;
            end else begin
              acc_reg   <= sum_next[ACC_WIDTH-1:0];
              ovf_reg   <= ovf_next;
              count_reg <= count_inc[LEN_WIDTH-1:0];
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = (state_reg == ACCUM);

  // ---------------- 2-entry result FIFO ----------------
  logic [ACC_WIDTH-1:0] mem_data [2];
  logic                 mem_ovf  [2];
  logic                 wr_ptr_reg;
  logic                 rd_ptr_reg;
  logic [1:0]           fifo_cnt_reg;
  logic                 fifo_full;
  logic                 pop;
  logic                 push_ok;
  logic                 push_drop;

  assign fifo_full = (fifo_cnt_reg == 2'd2);
  assign pop       = (fifo_cnt_reg != 2'd0) && res_ready;
  // A push into a full FIFO is fine when the head leaves in the same cycle:
  // the write slot is then the slot being vacated.
  assign push_ok   = last_prod && (!fifo_full || pop);
  assign push_drop = last_prod && fifo_full && !pop;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_data[gi] <= '0;
          mem_ovf[gi]  <= 1'b0;
        end else if (push_ok && (wr_ptr_reg == 1'(gi))) begin
          mem_data[gi] <= sum_next[ACC_WIDTH-1:0];
          mem_ovf[gi]  <= ovf_next;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      fifo_cnt_reg <= 2'd0;
    end else begin
      if (push_ok) wr_ptr_reg <= !wr_ptr_reg;
      if (pop)     rd_ptr_reg <= !rd_ptr_reg;
      case ({push_ok, pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 2'd1;
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 2'd1;
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

  assign res_valid = (fifo_cnt_reg != 2'd0);
  assign res_data  = mem_data[rd_ptr_reg];
  assign res_ovf   = mem_ovf[rd_ptr_reg];

  // ---------------- sticky error flags ----------------
  logic stray_set;
  assign stray_set = (state_reg == IDLE) && prod_valid;

  // A set event in the same cycle as err_clr keeps the flag high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overrun <= 1'b0;
      err_stray   <= 1'b0;
    end else begin
      if (push_drop)    err_overrun <= 1'b1;
      else if (err_clr) err_overrun <= 1'b0;
      if (stray_set)    err_stray   <= 1'b1;
      else if (err_clr) err_stray   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Self-checking bench for dot_product_accumulator. A reference model keeps
// full-precision vector sums and a queue standing in for the result FIFO;
// every cycle the DUT outputs are compared against it.
module tb_dot_product_accumulator;

  localparam int PW = 17;
  localparam int AW = 18;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] vec_len;
  logic          flush;
  logic          prod_valid;
  logic [PW-1:0] prod_data;
  logic          res_valid;
  logic          res_ready;
  logic [AW-1:0] res_data;
  logic          res_ovf;
  logic          busy;
  logic          err_clr;
  logic          err_overrun;
  logic          err_stray;

  always #5 clk = ~clk;

  dot_product_accumulator #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len), .flush(flush),
    .prod_valid(prod_valid), .prod_data(prod_data), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_ovf(res_ovf), .busy(busy),
    .err_clr(err_clr), .err_overrun(err_overrun), .err_stray(err_stray)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  longint m_q[$];       // full-precision sums waiting in the FIFO
  longint popped[$];    // sums that left the FIFO, in order
  bit     m_busy;
  int     m_len;
  int     m_cnt;
  longint m_sum;
  bit     m_ovr;
  bit     m_stray;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint exp_data(input longint s);
    return s & ((longint'(1) << AW) - 1);
  endfunction

  function automatic longint exp_ovf(input longint s);
    return ((s >> AW) != 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_busy  = 0;
    m_len   = 0;
    m_cnt   = 0;
    m_sum   = 0;
    m_ovr   = 0;
    m_stray = 0;
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, "_valid"}, res_valid, (m_q.size() != 0));
    if (m_q.size() != 0) begin
      check_eq({tag, "_data"}, res_data, exp_data(m_q[0]));
      check_eq({tag, "_ovf"}, res_ovf, exp_ovf(m_q[0]));
    end
    check_eq({tag, "_busy"}, busy, m_busy);
    check_eq({tag, "_overrun"}, err_overrun, m_ovr);
    check_eq({tag, "_stray"}, err_stray, m_stray);
  endtask

  // One clock cycle: apply inputs, advance the model, clock, compare.
  // Entered and left at 1 time unit after a rising edge.
  task automatic cycle(input bit st, input int len, input bit fl, input bit pv,
                       input int pd, input bit rdy, input bit clr, input string tag);
    bit     pop;
    bit     push;
    bit     ovr_set;
    bit     stray_set;
    longint done_sum;
    start      = st;
    vec_len    = LW'(len);
    flush      = fl;
    prod_valid = pv;
    prod_data  = PW'(pd);
    res_ready  = rdy;
    err_clr    = clr;

    pop       = (m_q.size() != 0) && rdy;
    push      = 0;
    ovr_set   = 0;
    stray_set = 0;
    done_sum  = 0;
    if (m_busy) begin
      if (fl) begin
        m_busy = 0;
      end else if (pv) begin
        m_sum += pd;
        m_cnt++;
        if (m_cnt == m_len) begin
          push     = 1;
          done_sum = m_sum;
          m_busy   = 0;
        end
      end
    end else begin
      if (pv) stray_set = 1;
      if (st && len != 0) begin
        m_busy = 1;
        m_len  = len;
        m_sum  = 0;
        m_cnt  = 0;
      end
    end
    if (pop) begin
      $display("[%0t] %s pop data=%0d ovf=%0d", $time, tag, res_data, res_ovf);
      popped.push_back(m_q.pop_front());
    end
    if (push) begin
      if (m_q.size() < 2) m_q.push_back(done_sum);
      else ovr_set = 1;
    end
    if (ovr_set) m_ovr = 1; else if (clr) m_ovr = 0;
    if (stray_set) m_stray = 1; else if (clr) m_stray = 0;

    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  // short helpers for directed stimulus
  task automatic idle(input bit rdy, input string tag);
    cycle(0, 0, 0, 0, 0, rdy, 0, tag);
  endtask
  task automatic go(input int len, input bit rdy, input string tag);
    cycle(1, len, 0, 0, 0, rdy, 0, tag);
  endtask
  task automatic prod(input int pd, input bit rdy, input string tag);
    cycle(0, 0, 0, 1, pd, rdy, 0, tag);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    vec_len    = '0;
    flush      = 1'b0;
    prod_valid = 1'b0;
    prod_data  = '0;
    res_ready  = 1'b0;
    err_clr    = 1'b0;
    model_reset();
    #12;
    check_eq("rst_valid", res_valid, 0);
    check_eq("rst_data", res_data, 0);
    check_eq("rst_ovf", res_ovf, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_overrun", err_overrun, 0);
    check_eq("rst_stray", err_stray, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 10+20+30, result visible the cycle after the last product, for one cycle
    go(3, 1, "tp1");
    prod(10, 1, "tp1");
    prod(20, 1, "tp1");
    prod(30, 1, "tp1");
    check_eq("tp1_sum", res_data, 60);
    check_eq("tp1_valid_up", res_valid, 1);
    check_eq("tp1_busy_down", busy, 0);
    idle(1, "tp1");
    check_eq("tp1_valid_one_cycle", res_valid, 0);

    // overflow: 5 x 65025 wraps an 18-bit accumulator
    go(5, 0, "tp2");
    for (int i = 0; i < 5; i++) prod(65025, 0, "tp2");
    check_eq("tp2_sum", res_data, 62981);
    check_eq("tp2_ovf", res_ovf, 1);
    idle(1, "tp2");

    // FIFO full: third result dropped
    popped.delete();
    go(1, 0, "tp3"); prod(7, 0, "tp3");
    go(1, 0, "tp3"); prod(8, 0, "tp3");
    go(1, 0, "tp3"); prod(9, 0, "tp3");
    check_eq("tp3_overrun", err_overrun, 1);
    idle(1, "tp3");
    idle(1, "tp3");
    idle(1, "tp3");
    check_eq("tp3_pop_count", popped.size(), 2);
    if (popped.size() == 2) begin
      check_eq("tp3_first", exp_data(popped[0]), 7);
      check_eq("tp3_second", exp_data(popped[1]), 8);
    end
    cycle(0, 0, 0, 0, 0, 0, 1, "tp3_clr");
    check_eq("tp3_cleared", err_overrun, 0);

    // full FIFO, third result lands in the same cycle as a pop
    popped.delete();
    go(1, 0, "tp4"); prod(1, 0, "tp4");
    go(1, 0, "tp4"); prod(2, 0, "tp4");
    go(1, 0, "tp4"); prod(3, 1, "tp4");
    check_eq("tp4_no_overrun", err_overrun, 0);
    for (int i = 0; i < 3; i++) idle(1, "tp4");
    check_eq("tp4_pop_count", popped.size(), 3);
    if (popped.size() == 3) begin
      check_eq("tp4_order0", exp_data(popped[0]), 1);
      check_eq("tp4_order1", exp_data(popped[1]), 2);
      check_eq("tp4_order2", exp_data(popped[2]), 3);
    end

    // flush discards the partial sum; stray product while idle
    popped.delete();
    go(4, 1, "tp5");
    prod(5, 1, "tp5");
    prod(6, 1, "tp5");
    cycle(0, 0, 1, 1, 100, 1, 0, "tp5_flush");
    check_eq("tp5_busy_after_flush", busy, 0);
    go(1, 1, "tp5");
    prod(3, 1, "tp5");
    idle(1, "tp5");
    idle(1, "tp5");
    check_eq("tp5_pop_count", popped.size(), 1);
    if (popped.size() == 1) check_eq("tp5_only", exp_data(popped[0]), 3);
    prod(1, 1, "tp5_stray");
    check_eq("tp5_stray_flag", err_stray, 1);
    cycle(0, 0, 0, 0, 0, 1, 1, "tp5_clr");

    // asynchronous reset mid-vector with one FIFO entry held
    go(1, 0, "tp6"); prod(4, 0, "tp6");
    go(3, 0, "tp6"); prod(1, 0, "tp6");
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("tp6_async_valid", res_valid, 0);
    check_eq("tp6_async_busy", busy, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    popped.delete();
    go(2, 0, "tp6");
    prod(1, 0, "tp6");
    prod(2, 0, "tp6");
    check_eq("tp6_sum", res_data, 3);
    idle(1, "tp6");
    idle(1, "tp6");
    check_eq("tp6_pop_count", popped.size(), 1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit st, fl, pv, rdy, clr;
      int len, pd;
      st  = ($urandom_range(0, 3) == 0);
      len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
      fl  = ($urandom_range(0, 19) == 0);
      pv  = ($urandom_range(0, 9) < 6);
      pd  = ($urandom_range(0, 7) == 0) ? 131071 : $urandom_range(0, 131071);
      rdy = ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 19) == 0);
      cycle(st, len, fl, pv, pd, rdy, clr, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
